// File: rtl/parking_exit_controller_if.sv
// Signal bundle for the parking exit lane controller.
// The lane hardware / bench drives through the master modport; the controller uses the slave modport.
interface parking_exit_controller_if #(
    parameter int CNT_W = 4
);
    logic             sensor_exit;
    logic             car_in;
    logic             ticket_valid;
    logic [1:0]       ticket_1;
    logic [1:0]       ticket_2;
    logic             attendant_clr;
    logic [2:0]       out;
    logic             gate_open;
    logic             alarm;
    logic             car_out;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;

    modport master (
        output sensor_exit, car_in, ticket_valid, ticket_1, ticket_2, attendant_clr,
        input  out, gate_open, alarm, car_out, occupancy, full, empty
    );

    modport slave (
        input  sensor_exit, car_in, ticket_valid, ticket_1, ticket_2, attendant_clr,
        output out, gate_open, alarm, car_out, occupancy, full, empty
    );
endinterface

// File: rtl/parking_exit_controller.sv
// Exit-lane controller: validates departing tickets, drives the exit barrier,
// locks the lane after repeated bad tickets and owns the lot occupancy count.
module parking_exit_controller #(
    parameter int         CAPACITY    = 8,
    parameter int         CNT_W       = 4,
    parameter logic [1:0] EXIT_CODE_1 = 2'b10,
    parameter logic [1:0] EXIT_CODE_2 = 2'b01,
    parameter int         MAX_TRIES   = 3,
    parameter int         TIMEOUT     = 255,
    parameter int         TMR_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    parking_exit_controller_if.slave bus
);
    // State encoding shared with the entry-gate controller; out is the state register itself.
    localparam logic [2:0] S_IDLE         = 3'b000;
    localparam logic [2:0] S_WAIT_TICKET  = 3'b001;
    localparam logic [2:0] S_WRONG_TICKET = 3'b010;
    localparam logic [2:0] S_GATE_OPEN    = 3'b011;
    localparam logic [2:0] S_LOCKOUT      = 3'b100;

    localparam int TRY_W = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRIES_LIMIT = TRY_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] TIMER_LIMIT = TMR_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] OCC_FULL    = CNT_W'(CAPACITY);

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [TRY_W-1:0] tries_inc;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             sensor_prev_q;
    logic             gate_q, alarm_q, car_out_q, full_q, empty_q;
    logic             match;
    logic             depart;

    assign match     = bus.ticket_valid && (bus.ticket_1 == EXIT_CODE_1) && (bus.ticket_2 == EXIT_CODE_2);
    assign tries_inc = tries_q + 1'b1;

    // Next-state logic for the exit FSM, ticket retry counter and idle timer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        tries_d = tries_q;
        depart  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // An empty lot means the loop is tripped by something that is not a parked car.
                if (bus.sensor_exit && !empty_q) begin
                    state_d = S_WAIT_TICKET;
                    timer_d = '0;
                    tries_d = '0;
                end
            end
            S_WAIT_TICKET, S_WRONG_TICKET: begin
                if (match) begin
                    state_d = S_GATE_OPEN;
                end else if (bus.ticket_valid) begin
                    tries_d = tries_inc;
                    if (tries_inc == TRIES_LIMIT) begin
                        state_d = S_LOCKOUT;
                    end else begin
                        state_d = S_WRONG_TICKET;
                        timer_d = '0;
                    end
                end else if (!bus.sensor_exit) begin
                    state_d = S_IDLE;
                end else if (timer_q == TIMER_LIMIT) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GATE_OPEN: begin
                // Departure is the falling edge of the loop sensor; no timeout while the car sits there.
                if (sensor_prev_q && !bus.sensor_exit) begin
                    state_d = S_IDLE;
                    depart  = 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (bus.attendant_clr) begin
                    state_d = S_IDLE;
                    tries_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Occupancy: admissions saturate at capacity, a simultaneous admit and depart cancel out.
    always_comb begin
        occ_d = occ_q;
        if (bus.car_in && !depart) begin
            if (occ_q != OCC_FULL) begin
                occ_d = occ_q + 1'b1;
            end
        end else if (depart && !bus.car_in) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // State, counters and registered outputs; an abort drops the gate immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            tries_q       <= '0;
            occ_q         <= '0;
            sensor_prev_q <= 1'b0;
            gate_q        <= 1'b0;
            alarm_q       <= 1'b0;
            car_out_q     <= 1'b0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            tries_q       <= tries_d;
            occ_q         <= occ_d;
            sensor_prev_q <= bus.sensor_exit;
            gate_q        <= (state_d == S_GATE_OPEN);
            alarm_q       <= (state_d == S_LOCKOUT);
            car_out_q     <= depart;
            full_q        <= (occ_d == OCC_FULL);
            empty_q       <= (occ_d == '0);
        end
    end

    assign bus.out       = state_q;
    assign bus.gate_open = gate_q;
    assign bus.alarm     = alarm_q;
    assign bus.car_out   = car_out_q;
    assign bus.occupancy = occ_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
endmodule

// File: tb/tb_parking_exit_controller.sv
// Self-checking bench for parking_exit_controller: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural lane model.
module tb_parking_exit_controller;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    parking_exit_controller_if #(.CNT_W(CNT_W)) bus();

    parking_exit_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef enum {P_IDLE, P_WAIT, P_WRONG, P_OPEN, P_LOCK} phase_t;

    phase_t m_phase;
    int     m_occ;
    int     m_tries;
    int     m_idle;
    bit     m_prev;
    bit     m_dep;

    int checks = 0;
    int errors = 0;

    function automatic logic [2:0] phase_code(phase_t p);
        case (p)
            P_IDLE:  return 3'b000;
            P_WAIT:  return 3'b001;
            P_WRONG: return 3'b010;
            P_OPEN:  return 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_occ   = 0;
        m_tries = 0;
        m_idle  = 0;
        m_prev  = 1'b0;
        m_dep   = 1'b0;
    endtask

    // One clock of lane behaviour, described from the rules of the lane rather than the RTL.
    task automatic model_step(input bit si, input bit ci, input bit tv,
                              input logic [1:0] t1, input logic [1:0] t2, input bit ac);
        bit good;
        bit departed;
        good     = tv && (t1 == 2'b10) && (t2 == 2'b01);
        departed = 1'b0;
        case (m_phase)
            P_IDLE: if (si && m_occ > 0) begin
                m_phase = P_WAIT; m_idle = 0; m_tries = 0;
            end
            P_WAIT, P_WRONG: begin
                if (good) m_phase = P_OPEN;
                else if (tv) begin
                    m_tries++;
                    if (m_tries == 3) m_phase = P_LOCK;
                    else begin m_phase = P_WRONG; m_idle = 0; end
                end else if (!si) m_phase = P_IDLE;
                else if (m_idle == 255) m_phase = P_IDLE;
                else m_idle++;
            end
            P_OPEN: if (m_prev && !si) begin
                m_phase = P_IDLE; departed = 1'b1;
            end
            default: if (ac) begin
                m_phase = P_IDLE; m_tries = 0;
            end
        endcase
        if (ci && !departed) m_occ = (m_occ >= 8) ? 8 : m_occ + 1;
        else if (departed && !ci) m_occ = m_occ - 1;
        m_prev = si;
        m_dep  = departed;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out",       8'(bus.out),       8'(phase_code(m_phase)));
        chk("gate_open", 8'(bus.gate_open), 8'(m_phase == P_OPEN));
        chk("alarm",     8'(bus.alarm),     8'(m_phase == P_LOCK));
        chk("car_out",   8'(bus.car_out),   8'(m_dep));
        chk("occupancy", 8'(bus.occupancy), 8'(m_occ));
        chk("full",      8'(bus.full),      8'(m_occ == 8));
        chk("empty",     8'(bus.empty),     8'(m_occ == 0));
    endtask

    task automatic cyc(input bit si, input bit ci, input bit tv,
                       input logic [1:0] t1, input logic [1:0] t2, input bit ac);
        bus.sensor_exit   = si;
        bus.car_in        = ci;
        bus.ticket_valid  = tv;
        bus.ticket_1      = t1;
        bus.ticket_2      = t2;
        bus.attendant_clr = ac;
        @(posedge clk);
        model_step(si, ci, tv, t1, t2, ac);
        #1;
        check_all();
        $display("cyc t=%0t si=%0b ci=%0b tv=%0b tk=%0b/%0b clr=%0b -> out=%0b gate=%0b alarm=%0b car_out=%0b occ=%0d",
                 $time, si, ci, tv, t1, t2, ac, bus.out, bus.gate_open, bus.alarm, bus.car_out, bus.occupancy);
    endtask

    initial begin
        bit si_r;
        bit tv_r;
        logic [1:0] t1_r, t2_r;

        reset_n           = 1'b0;
        bus.sensor_exit   = 1'b0;
        bus.car_in        = 1'b0;
        bus.ticket_valid  = 1'b0;
        bus.ticket_1      = 2'b00;
        bus.ticket_2      = 2'b00;
        bus.attendant_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_out", 8'(bus.out), 8'h00);
        chk("reset_empty", 8'(bus.empty), 8'h01);
        reset_n = 1'b1;

        // Admit three cars, one leaves with a good ticket.
        repeat (3) cyc(0, 1, 0, 2'b00, 2'b00, 0);
        cyc(1, 0, 0, 2'b00, 2'b00, 0);
        cyc(1, 0, 1, 2'b10, 2'b01, 0);
        chk("good_out", 8'(bus.out), 8'h03);
        chk("good_gate", 8'(bus.gate_open), 8'h01);
        cyc(1, 0, 0, 2'b00, 2'b00, 0);
        cyc(0, 0, 0, 2'b00, 2'b00, 0);
        chk("depart_pulse", 8'(bus.car_out), 8'h01);
        chk("depart_occ", 8'(bus.occupancy), 8'h02);
        chk("depart_out", 8'(bus.out), 8'h00);
        cyc(0, 0, 0, 2'b00, 2'b00, 0);
        chk("pulse_end", 8'(bus.car_out), 8'h00);

        // Two bad tickets then a good one.
        cyc(1, 0, 0, 2'b00, 2'b00, 0);
        chk("retry_wait", 8'(bus.out), 8'h01);
        cyc(1, 0, 1, 2'b00, 2'b00, 0);
        chk("retry_bad1", 8'(bus.out), 8'h02);
        cyc(1, 0, 1, 2'b00, 2'b00, 0);
        chk("retry_bad2", 8'(bus.out), 8'h02);
        chk("retry_alarm", 8'(bus.alarm), 8'h00);
        cyc(1, 0, 1, 2'b10, 2'b01, 0);
        chk("retry_good", 8'(bus.out), 8'h03);
        cyc(0, 0, 0, 2'b00, 2'b00, 0);

        // Three bad tickets lock the lane until the attendant clears it.
        cyc(1, 0, 0, 2'b00, 2'b00, 0);
        repeat (3) cyc(1, 0, 1, 2'b00, 2'b00, 0);
        chk("lock_out", 8'(bus.out), 8'h04);
        chk("lock_alarm", 8'(bus.alarm), 8'h01);
        cyc(1, 0, 1, 2'b10, 2'b01, 0);
        cyc(0, 0, 0, 2'b00, 2'b00, 0);
        chk("lock_hold", 8'(bus.out), 8'h04);
        cyc(0, 0, 0, 2'b00, 2'b00, 1);
        chk("clr_out", 8'(bus.out), 8'h00);
        chk("clr_alarm", 8'(bus.alarm), 8'h00);

        // Car sits on the loop without a ticket until the idle timeout.
        cyc(1, 0, 0, 2'b00, 2'b00, 0);
        repeat (255) cyc(1, 0, 0, 2'b00, 2'b00, 0);
        chk("tmo_still_wait", 8'(bus.out), 8'h01);
        cyc(1, 0, 0, 2'b00, 2'b00, 0);
        chk("tmo_idle", 8'(bus.out), 8'h00);
        // Last car departs, then a phantom on the loop of an empty lot.
        cyc(1, 0, 0, 2'b00, 2'b00, 0);
        cyc(1, 0, 1, 2'b10, 2'b01, 0);
        cyc(0, 0, 0, 2'b00, 2'b00, 0);
        chk("drain_empty", 8'(bus.empty), 8'h01);
        repeat (3) cyc(1, 0, 0, 2'b00, 2'b00, 0);
        chk("phantom_out", 8'(bus.out), 8'h00);
        cyc(0, 0, 0, 2'b00, 2'b00, 0);

        // Saturation at capacity and coincident admit/depart.
        repeat (9) cyc(0, 1, 0, 2'b00, 2'b00, 0);
        chk("sat_occ", 8'(bus.occupancy), 8'h08);
        chk("sat_full", 8'(bus.full), 8'h01);
        cyc(1, 0, 0, 2'b00, 2'b00, 0);
        cyc(1, 0, 1, 2'b10, 2'b01, 0);
        cyc(0, 1, 0, 2'b00, 2'b00, 0);
        chk("coinc_pulse", 8'(bus.car_out), 8'h01);
        chk("coinc_occ", 8'(bus.occupancy), 8'h08);

        // Randomized traffic against the model.
        si_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) == 0) si_r = ~si_r;
            tv_r = ($urandom_range(4) == 0);
            if ($urandom_range(1) == 0) begin
                t1_r = 2'b10; t2_r = 2'b01;
            end else begin
                t1_r = 2'($urandom); t2_r = 2'($urandom);
            end
            cyc(si_r, ($urandom_range(6) == 0), tv_r, t1_r, t2_r, ($urandom_range(19) == 0));
        end

        // Return to idle from any state, open the gate, then reset mid-exit.
        cyc(1, 0, 0, 2'b00, 2'b00, 1);
        cyc(0, 0, 0, 2'b00, 2'b00, 1);
        cyc(0, 0, 0, 2'b00, 2'b00, 1);
        cyc(0, 1, 0, 2'b00, 2'b00, 0);
        cyc(1, 0, 0, 2'b00, 2'b00, 0);
        cyc(1, 0, 1, 2'b10, 2'b01, 0);
        chk("pre_rst_gate", 8'(bus.gate_open), 8'h01);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_gate", 8'(bus.gate_open), 8'h00);
        chk("rst_out", 8'(bus.out), 8'h00);
        chk("rst_occ", 8'(bus.occupancy), 8'h00);
        chk("rst_empty", 8'(bus.empty), 8'h01);
        check_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(0, 0, 0, 2'b00, 2'b00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
